lsu_result_fifo: RTL
====================

# lsu_result_fifo

Result buffer between the load/store issue queue's DCache response port and the CDB arbiter. It accepts one `cdb_info_t` per cycle from the LSU issue queue (`entry_valid_o` / `fifo_ready` handshake). It holds results in order and presents the oldest one to the CDB with a valid/ready handshake. Flush discards every buffered result, which decouples DCache response timing from CDB arbitration stalls.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered results; power of two, ≥2.
- `PTR_LEN`, `$clog2(DEPTH)`: pointer width.

Ports:
- `clk`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush, synchronous; drops all contents.
- `entry_valid_i`  in  1  upstream result valid; driven from the issue queue's `entry_valid_o`.
- `entry_ready_o`  out  1  space available; drives the issue queue's `fifo_ready`.
- `result_i`  in  `cdb_info_t`  result payload; the issue queue's `result_o`.
- `cdb_valid_o`  out  1  head entry valid toward the CDB arbiter.
- `cdb_ready_i`  in  1  arbiter accepts the head entry.
- `cdb_o`  out  `cdb_info_t`  head entry payload.
- `count_o`  out  `PTR_LEN+1`  number of occupied entries.

## Operation
- Circular buffer `mem[DEPTH]` with registers `head_q`, `tail_q` (`PTR_LEN` bits, natural wrap) and `count_q` (`PTR_LEN+1` bits).
- Push: `push = entry_valid_i & entry_ready_o`. On a push, `mem[tail_q] <= result_i` and `tail_q` increments.
- Pop: `pop = cdb_valid_o & cdb_ready_i`. On a pop, `head_q` increments.
- Count: `count_q <= count_q + push - pop`.
- `entry_ready_o = (count_q != DEPTH)`. This is purely a function of registered state; there is no combinational path from `cdb_ready_i`. When full, a push is refused even if a pop happens in the same cycle.
- `cdb_valid_o = (count_q != 0)`. `cdb_o = mem[head_q]` combinationally. `cdb_o` holds stable while `cdb_valid_o & ~cdb_ready_i`.
- `count_o = count_q`.
- Entries are stored regardless of `result_i.r_valid`. Bubble filtering is the CDB's concern.
- Flush or reset:
  - `head_q`, `tail_q` and `count_q` clear to 0 at the next edge.
  - A push or pop in the same cycle is ignored.
  - `mem` is not cleared by flush.
- Reset additionally clears `mem` to `'0`.

## Timing
- Reset values:
  - `entry_ready_o = 1`
  - `cdb_valid_o = 0`
  - `count_o = 0`
  - `cdb_o = '0`
- Latency: a result pushed in cycle N is visible on `cdb_o` with `cdb_valid_o = 1` in cycle N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained. Simultaneous push and pop at `0 < count < DEPTH` leaves the count unchanged.
- Empty: pop is impossible because `cdb_valid_o = 0`. A push into an empty buffer makes `count_q = 1` next cycle.
- Full (`count_q = DEPTH`): `entry_ready_o = 0`. A pop in that cycle makes `entry_ready_o = 1` the next cycle.
- Wrap: pointers roll from `DEPTH-1` to 0 with no special case. Ordering is preserved across the wrap.
- Flush mid-stall: if `cdb_valid_o` was high with `cdb_ready_i` low, then `cdb_valid_o` drops to 0 in the cycle after `flush`. The arbiter must not depend on the entry persisting.
- Flush and reset have equal priority over push and pop. Reset has priority over flush.

## Structure
- `cdb_info_t` and the LSU packages stay in `a_defines.svh`. No new typedef is required.
- `DEPTH` is a local parameter default only. There is no global constant.
- Single module, no submodules. Pointer and count logic is in one `always_ff`; ready/valid are assigned by `assign`.

## Test plan
- Reset, then idle: `entry_ready_o = 1`, `cdb_valid_o = 0`, `count_o = 0`, `cdb_o = '0`.
- Push `rob_id` values 5, 6, 7, 8 on consecutive cycles with `cdb_ready_i = 0`:
  - `count_o` steps 1..4.
  - `entry_ready_o = 0` after the 4th push.
  - A 5th push (`rob_id = 9`) is refused.
  - `cdb_o.rob_id` stays 5.
- From full, set `cdb_ready_i = 1` for 4 cycles: pop order is `rob_id` 5, 6, 7, 8. `entry_ready_o = 1` the cycle after the first pop. `cdb_valid_o = 0` after the last pop.
- Streaming with `cdb_ready_i = 1` and continuous pushes `rob_id = 0..11` (3× wrap): `count_o` stays 1. Outputs appear in the same order, one cycle after each push.
- With 3 entries buffered, assert `flush` together with a push of `rob_id = 20`: next cycle `count_o = 0` and `cdb_valid_o = 0`. The following push of `rob_id = 21` appears at the head one cycle later.
- Assert `rst` in the same cycle as `flush` and a push: all outputs return to their reset values. `rst` takes precedence, so `mem` reads `'0`.

Source files
------------

// File: rtl/lsu_result_fifo_pkg.sv
// Shared types for the LSU result buffer: the CDB result record it stores.
package lsu_result_fifo_pkg;

  localparam int ROB_ID_W = 6;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic                r_valid;
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   data;
  } cdb_info_t;

endpackage

// File: rtl/lsu_result_fifo.sv
// In-order LSU result buffer feeding the CDB arbiter; one-cycle push-to-head latency, no bypass.
// Upstream ready depends only on occupancy (full refuses a push even with a same-cycle pop).
module lsu_result_fifo
  import lsu_result_fifo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PTR_LEN = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             entry_valid_i,
  output logic             entry_ready_o,
  input  cdb_info_t        result_i,
  output logic             cdb_valid_o,
  input  logic             cdb_ready_i,
  output cdb_info_t        cdb_o,
  output logic [PTR_LEN:0] count_o
);

  localparam logic [PTR_LEN:0] FULL_CNT = (PTR_LEN + 1)'(DEPTH);

  cdb_info_t          mem [DEPTH];
  logic [PTR_LEN-1:0] head_q;
  logic [PTR_LEN-1:0] tail_q;
  logic [PTR_LEN:0]   count_q;
  logic               push;
  logic               pop;

  assign entry_ready_o = (count_q != FULL_CNT);
  assign cdb_valid_o   = (count_q != '0);
  assign cdb_o         = mem[head_q];
  assign count_o       = count_q;

  assign push = entry_valid_i & entry_ready_o;
  assign pop  = cdb_valid_o & cdb_ready_i;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + {{PTR_LEN{1'b0}}, push} - {{PTR_LEN{1'b0}}, pop};
    end
  end

  // Flush leaves stale payloads in place; only reset scrubs the storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[tail_q] <= result_i;
    end
  end

endmodule
